// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared widths, FSM states and divide-by-zero constants
// for the divider arbiter and its sequential datapath.
package div_arb_pkg;

  localparam int DATA_W = 16;
  localparam int ITER_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 16'hFFFF;

endpackage

// File: rtl/div_seq_core.sv
// div_seq_core: 16-step restoring divider, one iteration per step pulse.
// quot/rem present the result of the current step; done marks the last one.
module div_seq_core
  import div_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              done
);

  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] d_q;
  logic [ITER_W-1:0] cnt_q;
  logic [DATA_W:0]   r_sh;
  logic [DATA_W-1:0] r_nx;
  logic [DATA_W-1:0] q_nx;

  // a restored remainder is always below the divisor, so 16 bits hold it
  always_comb begin
    r_sh = {r_q, q_q[DATA_W-1]};
    if (r_sh >= {1'b0, d_q}) begin
      r_nx = r_sh[DATA_W-1:0] - d_q;
      q_nx = {q_q[DATA_W-2:0], 1'b1};
    end else begin
      r_nx = r_sh[DATA_W-1:0];
      q_nx = {q_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      r_q   <= '0;
      q_q   <= dividend;
      d_q   <= divisor;
      cnt_q <= '0;
    end else if (step) begin
      r_q   <= r_nx;
      q_q   <= q_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign quot = q_nx;
  assign rem  = r_nx;
  assign done = step && (cnt_q == ITER_W'(DATA_W-1));

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one sequential divider.
// Optional DIV_ZERO_CHK_EN short-circuits zero divisors and flags rsp_err.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_quot,
  output logic [DATA_W-1:0]        rsp_rem,
  output logic                     rsp_err,
  output logic                     busy
);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   gidx;
  logic [ID_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant;
  logic              found;
  logic              hs;
  logic [DATA_W-1:0] dvd_sel;
  logic [DATA_W-1:0] dvs_sel;
  logic [DATA_W-1:0] core_quot;
  logic [DATA_W-1:0] core_rem;
  logic              core_done;

  // first valid requester scanning upward from ptr+1
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        gidx        = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign hs        = rst_n && (state == IDLE) && found;
  assign dvd_sel   = req_dividend[int'(gidx)*DATA_W +: DATA_W];
  assign dvs_sel   = req_divisor[int'(gidx)*DATA_W +: DATA_W];
  assign busy      = (state != IDLE);

  div_seq_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hs),
    .step     (state == BUSY),
    .dividend (dvd_sel),
    .divisor  (dvs_sel),
    .quot     (core_quot),
    .rem      (core_rem),
    .done     (core_done)
  );

`ifdef DIV_ZERO_CHK_EN
  logic              div0_q;
  logic [DATA_W-1:0] dvd_q;
  logic              err_q;

  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ-1);
      id_q      <= '0;
      div0_q    <= 1'b0;
      dvd_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          ptr    <= gidx;
          id_q   <= gidx;
          div0_q <= (dvs_sel == '0);
          dvd_q  <= dvd_sel;
          state  <= BUSY;
        end
        BUSY: if (div0_q) begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_quot  <= DIV0_QUOT;
          rsp_rem   <= dvd_q;
          err_q     <= 1'b1;
        end else if (core_done) begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_quot  <= core_quot;
          rsp_rem   <= core_rem;
          err_q     <= 1'b0;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign rsp_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(NUM_REQ-1);
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quot  <= '0;
      rsp_rem   <= '0;
    end else begin
      unique case (state)
        IDLE: if (hs) begin
          ptr   <= gidx;
          id_q  <= gidx;
          state <= BUSY;
        end
        BUSY: if (core_done) begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_quot  <= core_quot;
          rsp_rem   <= core_rem;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed scoreboard bench for the shared divider arbiter.
// Expected results come from a behavioural divide model.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef DIV_ZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_dividend;
  logic [N*16-1:0] req_divisor;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [15:0]     rsp_quot;
  logic [15:0]     rsp_rem;
  logic            rsp_err;
  logic            busy;

  always #5 clk = ~clk;

  div_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_quot     (rsp_quot),
    .rsp_rem      (rsp_rem),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [15:0]   q;
    logic [15:0]   r;
    logic          e;
  } exp_t;

  exp_t sb[$];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input int id, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    e.id = IW'(id);
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.e = DZ;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.e = 1'b0;
    end
    return e;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    req_dividend[16*i +: 16] = a;
    req_divisor[16*i +: 16]  = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic issue(input int i, input logic [15:0] a,
                       input logic [15:0] b);
    int n;
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    n = 0;
    #1;
    while (!req_ready[i] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_wait", {31'b0, req_ready[i]}, 32'd1);
    @(posedge clk);
    sb.push_back(model(i, a, b));
    @(negedge clk);
    req_valid[i] = 1'b0;
    set_op(i, 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic take_rsp();
    exp_t e;
    chk("sb_nonempty", {31'b0, sb.size() > 0}, 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk("rsp_id", 32'(rsp_id), 32'(e.id));
    chk("rsp_quot", 32'(rsp_quot), 32'(e.q));
    chk("rsp_rem", 32'(rsp_rem), 32'(e.r));
    chk("rsp_err", 32'(rsp_err), 32'(e.e));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic run_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    int lat;
    issue(i, a, b);
    wait_rsp(lat);
    chk("latency", 32'(lat), (DZ && b == 16'd0) ? 32'd1 : 32'd16);
    take_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] da [N];
    logic [15:0] db [N];
    logic [15:0] hq, hr;
    logic [IW-1:0] hid;
    logic stable, seen;
    int lat;

    req_dividend = '0;
    req_divisor  = '0;
    do_reset();
    #1;
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_quot", 32'(rsp_quot), 32'd0);
    chk("rst_rem", 32'(rsp_rem), 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);

    run_op(0, 16'd65535, 16'd65535);

    // rsp_ready held high while idle/busy must not matter
    rsp_ready = 1'b1;
    issue(1, 16'd64, 16'd3);
    rsp_ready = 1'b0;
    wait_rsp(lat);
    chk("latency", 32'(lat), 32'd16);
    take_rsp();
    run_op(1, 16'd100, 16'd2);
    run_op(1, 16'd30, 16'd15);
    run_op(1, 16'd15, 16'd2);

    // round robin from reset with every requester asserting
    do_reset();
    da = '{16'd50000, 16'd777, 16'd4096, 16'd9};
    db = '{16'd123, 16'd10, 16'd17, 16'd200};
    for (int i = 0; i < N; i++) set_op(i, da[i], db[i]);
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % N)));
      @(posedge clk);
      sb.push_back(model(g % N, da[g % N], db[g % N]));
      @(negedge clk);
      chk("busy_ready0", 32'(req_ready), 32'd0);
      chk("busy_flag", {31'b0, busy}, 32'd1);
      wait_rsp(lat);
      chk("rr_latency", 32'(lat), 32'd16);
      take_rsp();
    end
    req_valid = '0;

    // backpressure with requester 3 waiting
    set_op(3, 16'd5555, 16'd11);
    req_valid[3] = 1'b1;
    issue(2, 16'd1000, 16'd7);
    wait_rsp(lat);
    hq = rsp_quot;
    hr = rsp_rem;
    hid = rsp_id;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_quot !== hq || rsp_rem !== hr || rsp_id !== hid)
        stable = 1'b0;
      chk("bp_ready0", 32'(req_ready), 32'd0);
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    take_rsp();
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'd8);
    @(posedge clk);
    sb.push_back(model(3, 16'd5555, 16'd11));
    @(negedge clk);
    req_valid[3] = 1'b0;
    wait_rsp(lat);
    take_rsp();

    run_op(1, 16'd1234, 16'd0);

    // reset mid-operation discards the result
    issue(0, 16'd200, 16'd7);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_quot", 32'(rsp_quot), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_stale_rsp", {31'b0, seen}, 32'd0);
    run_op(0, 16'd200, 16'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one sequential 16-bit restoring divider among NUM_REQ requesters. Grants are round-robin, per-requester valid/ready on the request side, and one tagged, backpressured response port. Placed between the arithmetic clients and the divide datapath, it sequences operand load, 16 iterations and result hand-off.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, $clog2(NUM_REQ): width of the requester tag.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_dividend  input  NUM_REQ*16  packed dividends; slice i = bits [16i+15:16i].
- req_divisor  input  NUM_REQ*16  packed divisors, same packing.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that issued the result.
- rsp_quot  output  16  quotient.
- rsp_rem  output  16  remainder.
- rsp_err  output  1  divisor was zero (only when DIV_ZERO_CHK_EN is defined; otherwise tied 0).
- busy  output  1  state != IDLE.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: the round-robin grant picks the first req_valid at or after index ptr+1 (mod NUM_REQ).
  - req_ready[i] = IDLE & grant[i], combinational from req_valid.
  - On handshake: latch operands and id, set ptr = i, clear the iteration counter, go to BUSY.
- BUSY: one restoring iteration per cycle.
  - Partial remainder r (17 bits) = {r[15:0], q[15]}; q shifts left.
  - If r >= {1'b0, divisor}: r -= divisor and q[0]=1; else q[0]=0.
  - After the 16th iteration, go to DONE.
- DONE: rsp_valid=1. Outputs stay stable until rsp_valid & rsp_ready, then go to IDLE.
- No request is accepted in DONE or BUSY. req_ready is all-zero there.
- All arithmetic is unsigned. Results: quot = floor(dividend/divisor), rem = dividend - quot*divisor; rem < divisor always holds for nonzero divisor.
- Divisor zero, normal algorithm: quot=16'hFFFF, rem=dividend.
- Requester operands need to be stable only in the handshake cycle.

## Timing
- Reset values:
  - state=IDLE, ptr=NUM_REQ-1 (so index 0 has first priority).
  - rsp_valid=0, rsp_id=0, rsp_quot=0, rsp_rem=0, rsp_err=0, busy=0, req_ready=0.
- Latency: for a handshake at edge E0, rsp_valid rises after edge E16 (16 cycles later).
- Minimum issue interval is 18 cycles: 16 BUSY cycles, 1 DONE cycle, 1 IDLE cycle.
- Backpressure: DONE is held for any number of cycles while rsp_ready=0. The result does not change.
- rsp_ready is ignored while rsp_valid=0.
- If several requesters are valid in the same cycle, exactly one is granted. A requester left waiting is granted within NUM_REQ-1 later grants.
- req_valid dropping before its handshake cancels that request with no side effects.
- Asserting rst_n low at any time, including mid-BUSY or mid-DONE, immediately returns all reset values and discards the in-flight operation. No response is ever emitted for it.

## Configuration
- DIV_ZERO_CHK_EN defined:
  - A zero divisor seen at the handshake skips BUSY and goes to DONE on the next edge, so rsp_valid appears 1 cycle after acceptance.
  - Results: quot=16'hFFFF, rem=dividend, rsp_err=1.
  - rsp_err is 0 for every nonzero divisor.
- DIV_ZERO_CHK_EN undefined:
  - No detection logic.
  - A zero divisor runs the full 16 iterations and yields quot=16'hFFFF, rem=dividend.
  - rsp_err is constant 0.

## Structure
- Package div_arb_pkg holds:
  - DATA_W=16 and ITER_W=5.
  - The state enum (IDLE, BUSY, DONE).
  - The results for a zero divisor: DIV0_QUOT=16'hFFFF.
- Sub-module div_seq_core contains the datapath and is driven by the arbiter FSM:
  - Inputs: load, step, dividend, divisor.
  - Outputs: quot, rem, done after 16 steps.
- The arbiter holds the FSM, the round-robin pointer, the id register and the response hold registers.

## Test plan
- Single requester 0: 65535/65535 -> rsp_quot=1, rsp_rem=0, rsp_id=0, rsp_valid exactly 16 cycles after the handshake.
- Sequential ops on requester 1: 64/3 -> 21 r1; 100/2 -> 50 r0; 30/15 -> 2 r0; 15/2 -> 7 r1.
- All 4 requesters valid continuously with distinct operands -> grant order 0,1,2,3,0. Every rsp_id matches its operands and no requester is starved.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_* stay stable, req_ready stays 0, and the next grant comes only after the rsp handshake.
- Divisor 0, dividend 1234:
  - With DIV_ZERO_CHK_EN: quot=65535, rem=1234, err=1, latency 1 cycle.
  - Without it: same quot and rem, err=0, latency 16 cycles.
- Pulse rst_n low at iteration 8 of 200/7 -> outputs return to reset values immediately and no response appears. A following 200/7 returns 28 r4.
